// File: rtl/tile_line_renderer.sv
// Background tile stage: walks one row of the 32x32 tile map, fetches 16x16 tile rows
// from tile VRAM and streams one palette index per clk_pix cycle into the next-line buffer.
// Each 8-pixel word takes 8 cycles to emit, and the TAM/VRAM fetch of the next word is
// hidden under those 8 cycles. As a result, the slots of consecutive words follow each
// other with no gap.
module tile_line_renderer #(
   parameter int H_RES    = 640,
   parameter int MAP_BITS = 5
) (
   input  logic                    clk_pix,
   input  logic                    btn_rst,
   input  logic                    start,
   input  logic [9:0]              line,
   input  logic [MAP_BITS+3:0]     scroll_x,
   input  logic [MAP_BITS+3:0]     scroll_y,
   output logic                    busy,
   output logic                    done,
   output logic [2*MAP_BITS-1:0]   tam_addr,
   input  logic [15:0]             tam_data,
   output logic [11:0]             vram_addr,
   input  logic [127:0]            vram_data,
   output logic                    lb_we,
   output logic [9:0]              lb_addr,
   output logic [7:0]              lb_data
);
   localparam int         WB        = MAP_BITS + 4;      // world coordinate width
   localparam logic [6:0] LAST_WORD = 7'(H_RES / 8);     // one extra word covers a misaligned scroll
   localparam logic [9:0] N_SLOTS   = 10'(H_RES + 8);
   localparam logic [9:0] X_LAST    = 10'(H_RES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   state_t          state_r, state_s;
   logic [2:0]      phase_r;        // position inside the 8-cycle word period
   logic [6:0]      word_r;         // word currently being fetched
   logic            more_r;         // words remain to be fetched
   logic            load_r;         // vram_data holds a fetched word this cycle
   logic            flip_r;         // hflip of the word in flight
   logic [WB-1:0]   wx_r;           // world x of the word being fetched
   logic [WB-1:0]   wx_next_s;
   logic [WB-1:0]   wy_s;
   logic [MAP_BITS-1:0] trow_r;
   logic [3:0]      rit_r;          // row inside the tile
   logic [2:0]      off_r;          // sub-word scroll offset
   logic [11:0]     vhold_r;        // last issued VRAM address, held while not fetching
   logic [9:0]      slot_r;         // index of the next slot to present
   logic [55:0]     shift_r;        // remaining slots of the current word
   logic [63:0]     ord_s;          // fetched word in slot order
   logic [9:0]      x_s;
   logic            we_s;
   logic            active_s;
   logic            vis_s;          // VRAM address issue cycle
   logic            unused_s;

   // Reorders the 8 pixels of a VRAM word into slot order; the upper byte of each pixel is ignored.
   function automatic logic [63:0] order_pixels(input logic [127:0] word, input logic flip);
      logic [63:0] res;
      res = 64'd0;
      for (int j = 0; j < 8; j++) begin
         if (flip) begin
            res[8*j +: 8] = word[16*(7-j) +: 8];
         end else begin
            res[8*j +: 8] = word[16*j +: 8];
         end
      end
      return res;
   endfunction

   // Parity over the reserved TAM bits and the unused top line bit; these inputs carry no function.
   function automatic logic reserved_parity(input logic [8:0] bits);
      return ^bits;
   endfunction

   assign unused_s  = reserved_parity({tam_data[15:8], line[9]});
   assign wy_s      = line[WB-1:0] + scroll_y;
   assign wx_next_s = wx_r + WB'(8);
   assign active_s  = (state_r == FILL) || (state_r == RUN);
   assign vis_s     = active_s && (phase_r == 3'd1) && more_r;
   assign ord_s     = order_pixels(vram_data, flip_r);
   assign x_s       = slot_r - {7'd0, off_r};
   assign we_s      = (slot_r >= {7'd0, off_r}) && (x_s <= X_LAST);
   assign busy      = active_s;
   assign done      = (state_r == DONE);

   // VRAM address follows the TAM entry in its issue cycle and is otherwise held.
   always_comb begin
      if (vis_s) begin
         vram_addr = {tam_data[6:0], rit_r, wx_r[3] ^ tam_data[7]};
      end else begin
         vram_addr = vhold_r;
      end
   end

   // Next-state logic: a start is only taken in IDLE, so starts while busy or during DONE are dropped.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (start)              state_s = FILL; else state_s = IDLE;
         FILL:    if (load_r)             state_s = RUN;  else state_s = FILL;
         RUN:     if (slot_r == N_SLOTS)  state_s = DONE; else state_s = RUN;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_pix or negedge btn_rst) begin
      if (!btn_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Fetch sequencer: latches the line geometry on start, then issues one TAM/VRAM fetch per word.
   always_ff @(posedge clk_pix or negedge btn_rst) begin
      if (!btn_rst) begin
         phase_r  <= 3'd0;
         word_r   <= 7'd0;
         more_r   <= 1'b0;
         load_r   <= 1'b0;
         flip_r   <= 1'b0;
         wx_r     <= '0;
         trow_r   <= '0;
         rit_r    <= 4'd0;
         off_r    <= 3'd0;
         vhold_r  <= 12'd0;
         tam_addr <= '0;
      end else if (state_r == IDLE) begin
         load_r <= 1'b0;
         if (start) begin
            tam_addr <= {wy_s[WB-1:4], scroll_x[WB-1:4]};
            trow_r   <= wy_s[WB-1:4];
            rit_r    <= wy_s[3:0];
            wx_r     <= {scroll_x[WB-1:3], 3'b000};
            off_r    <= scroll_x[2:0];
            phase_r  <= 3'd0;
            word_r   <= 7'd0;
            more_r   <= 1'b1;
         end
      end else begin
         phase_r <= phase_r + 3'd1;
         load_r  <= vis_s;
         if (vis_s) begin
            vhold_r <= vram_addr;
            flip_r  <= tam_data[7];
         end
         if (active_s && (phase_r == 3'd7) && more_r) begin
            if (word_r == LAST_WORD) begin
               more_r <= 1'b0;
            end else begin
               word_r   <= word_r + 7'd1;
               wx_r     <= wx_next_s;
               tam_addr <= {trow_r, wx_next_s[WB-1:4]};
            end
         end
      end
   end

   // Pixel output: load a fetched word, then shift one slot per cycle onto the line-buffer port.
   always_ff @(posedge clk_pix or negedge btn_rst) begin
      if (!btn_rst) begin
         slot_r  <= 10'd0;
         shift_r <= 56'd0;
         lb_we   <= 1'b0;
         lb_addr <= 10'd0;
         lb_data <= 8'd0;
      end else if (state_r == IDLE) begin
         slot_r <= 10'd0;
         lb_we  <= 1'b0;
      end else if (load_r || ((state_r == RUN) && (slot_r != N_SLOTS))) begin
         if (load_r) begin
            lb_data <= ord_s[7:0];
            shift_r <= ord_s[63:8];
         end else begin
            lb_data <= shift_r[7:0];
            shift_r <= {8'd0, shift_r[55:8]};
         end
         lb_we   <= we_s;
         lb_addr <= x_s;
         slot_r  <= slot_r + 10'd1;
      end else begin
         lb_we <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tile_line_renderer.sv
module tb_tile_line_renderer;
   logic         clk_pix = 1'b0;
   logic         btn_rst;
   logic         start;
   logic [9:0]   line;
   logic [8:0]   scroll_x;
   logic [8:0]   scroll_y;
   logic         busy;
   logic         done;
   logic [9:0]   tam_addr;
   logic [15:0]  tam_data;
   logic [11:0]  vram_addr;
   logic [127:0] vram_data;
   logic         lb_we;
   logic [9:0]   lb_addr;
   logic [7:0]   lb_data;

   logic [15:0]  tam_mem  [0:1023];
   logic [127:0] vram_mem [0:4095];

   int          n_total = 0;
   int          n_bad   = 0;
   int unsigned tick    = 0;
   int unsigned t0      = 0;
   int          wr_cnt, first_cyc, last_cyc, done_cnt, mon_rel;
   logic [17:0] exp_q [$];
   logic [17:0] ent;

   tile_line_renderer #(.H_RES(640), .MAP_BITS(5)) dut (
      .clk_pix(clk_pix), .btn_rst(btn_rst), .start(start), .line(line),
      .scroll_x(scroll_x), .scroll_y(scroll_y), .busy(busy), .done(done),
      .tam_addr(tam_addr), .tam_data(tam_data), .vram_addr(vram_addr),
      .vram_data(vram_data), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
   );

   always #5 clk_pix = ~clk_pix;

   always @(posedge clk_pix) tick <= tick + 1;

   // Synchronous-read memories, one cycle of latency.
   always @(posedge clk_pix) begin
      tam_data  <= tam_mem[tam_addr];
      vram_data <= vram_mem[vram_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] tile_pix(input logic [6:0] id, input logic [3:0] row, input logic [3:0] p);
      logic [127:0] w;
      w = vram_mem[{id, row, p[3]}];
      return w[16*p[2:0] +: 8];
   endfunction

   // Pixel-level reference: every screen x maps to a world pixel through the map.
   task automatic build_expect(input logic [9:0] ln, input logic [8:0] sx, input logic [8:0] sy);
      logic [8:0]  wy, wx;
      logic [15:0] e;
      logic [3:0]  p;
      exp_q.delete();
      wy = ln[8:0] + sy;
      for (int x = 0; x < 640; x++) begin
         wx = sx + 9'(x);
         e  = tam_mem[{wy[8:4], wx[8:4]}];
         p  = wx[3:0];
         if (e[7]) p = 4'd15 - p;
         exp_q.push_back({10'(x), tile_pix(e[6:0], wy[3:0], p)});
      end
   endtask

   // Scoreboard consumer: every line-buffer write is popped and compared in order.
   always @(negedge clk_pix) begin
      if (btn_rst === 1'b1) begin
         if (done) done_cnt++;
         if (lb_we) begin
            mon_rel = int'(tick - t0);
            if (wr_cnt == 0) first_cyc = mon_rel;
            last_cyc = mon_rel;
            wr_cnt++;
            check_eq("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               ent = exp_q.pop_front();
               check_eq("lb_addr", lb_addr, ent[17:8]);
               check_eq("lb_data", lb_data, ent[7:0]);
            end
         end
      end
   end

   // Renders one line; called on a falling edge, returns on the falling edge of cycle 653.
   task automatic render(input logic [9:0] ln, input logic [8:0] sx, input logic [8:0] sy, input bit noise);
      logic [8:0]  wy;
      logic [9:0]  ta;
      logic [15:0] e;
      int          rel;
      build_expect(ln, sx, sy);
      wy = ln[8:0] + sy;
      ta = {wy[8:4], sx[8:4]};
      e  = tam_mem[ta];
      line = ln; scroll_x = sx; scroll_y = sy; start = 1'b1;
      t0 = tick; wr_cnt = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0;
      @(negedge clk_pix);
      start = 1'b0;
      check_eq("busy_c1", busy, 1);
      check_eq("tam_addr_c1", tam_addr, ta);
      @(negedge clk_pix);
      check_eq("vram_addr_c2", vram_addr, {e[6:0], wy[3:0], sx[3] ^ e[7]});
      rel = int'(tick - t0);
      while (!done && rel < 1000) begin
         if (noise && rel == 100) begin
            start = 1'b1; line = 10'd77; scroll_x = 9'd33; scroll_y = 9'd99;
         end else begin
            start = 1'b0;
         end
         @(negedge clk_pix);
         rel = int'(tick - t0);
      end
      check_eq("done_cycle", rel, 652);
      check_eq("busy_at_done", busy, 0);
      if (noise) begin
         start = 1'b1; line = 10'd5; scroll_x = 9'd7; scroll_y = 9'd11;
      end
      @(negedge clk_pix);
      start = 1'b0;
      if (noise) check_eq("busy_c653", busy, 0);
      check_eq("write_count", wr_cnt, 640);
      check_eq("first_write_cycle", first_cyc, 4 + int'(sx[2:0]));
      check_eq("last_write_cycle", last_cyc, 643 + int'(sx[2:0]));
      check_eq("writes_left", exp_q.size(), 0);
      check_eq("done_pulses", done_cnt, 1);
   endtask

   initial begin
      for (int id = 0; id < 128; id++)
         for (int row = 0; row < 16; row++)
            for (int h = 0; h < 2; h++)
               for (int j = 0; j < 8; j++)
                  vram_mem[id*32 + row*2 + h][16*j +: 16] = {8'hA5 ^ 8'(j), 8'(id*16 + h*8 + j + row*7)};
      for (int i = 0; i < 1024; i++) begin
         if (i < 40) tam_mem[i] = {8'hC3, 1'b0, 7'(i)};
         else        tam_mem[i] = {8'h3C, 1'((i * 5) >> 3), 7'((i * 37) % 128)};
      end

      btn_rst = 1'b0; start = 1'b0; line = 10'd0; scroll_x = 9'd0; scroll_y = 9'd0;
      done_cnt = 0; wr_cnt = 0;
      repeat (3) @(negedge clk_pix);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_lb_we", lb_we, 0);
      check_eq("rst_lb_addr", lb_addr, 0);
      check_eq("rst_lb_data", lb_data, 0);
      check_eq("rst_tam_addr", tam_addr, 0);
      check_eq("rst_vram_addr", vram_addr, 0);
      btn_rst = 1'b1;
      repeat (2) @(negedge clk_pix);

      render(10'd0,   9'd0,   9'd0,   1'b0);   // basic
      render(10'd0,   9'd3,   9'd0,   1'b0);   // misaligned scroll
      render(10'd20,  9'd500, 9'd500, 1'b0);   // horizontal and vertical wrap
      render(10'd300, 9'd123, 9'd45,  1'b1);   // ignored starts at 100 and 652
      render(10'd301, 9'd77,  9'd45,  1'b0);   // accepted at 653
      tam_mem[0] = {8'h5A, 1'b1, 7'd5};
      render(10'd0,   9'd0,   9'd0,   1'b0);   // hflip

      // Abort mid-line by reset.
      build_expect(10'd3, 9'd40, 9'd9);
      line = 10'd3; scroll_x = 9'd40; scroll_y = 9'd9; start = 1'b1;
      t0 = tick; done_cnt = 0; wr_cnt = 0;
      @(negedge clk_pix);
      start = 1'b0;
      while (int'(tick - t0) < 300) @(negedge clk_pix);
      btn_rst = 1'b0;
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_lb_we", lb_we, 0);
      check_eq("abort_lb_addr", lb_addr, 0);
      check_eq("abort_lb_data", lb_data, 0);
      check_eq("abort_tam_addr", tam_addr, 0);
      check_eq("abort_vram_addr", vram_addr, 0);
      repeat (3) @(negedge clk_pix);
      btn_rst = 1'b1;
      exp_q.delete();
      while (int'(tick - t0) < 700) @(negedge clk_pix);
      check_eq("abort_no_done", done_cnt, 0);
      check_eq("abort_idle", busy, 0);
      render(10'd3, 9'd40, 9'd9, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
